// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC bus-decode enums and UART register map constants.
package soc_pkg;
  typedef enum logic [1:0] {BLK_MEM = 2'h0, BLK_UART = 2'h1, BLK_GPIO = 2'h2, BLK_TIMER = 2'h3} e_block_sel;
  typedef enum logic [1:0] {CS_ROM = 2'h0, CS_RAM = 2'h1, CS_PERIPH = 2'h2, CS_NONE = 2'h3} e_chip_sel;
  typedef enum logic [1:0] {DATA = 2'h0, STATUS = 2'h1, DIV = 2'h2} e_uart_reg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} e_uart_st;
  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_TX_BUSY   = 2;
  localparam int unsigned ST_RX_EMPTY  = 3;
  localparam int unsigned ST_RX_FULL   = 4;
  localparam int unsigned ST_RX_OVF    = 5;
  localparam int unsigned ST_TX_OVF    = 6;
  localparam int unsigned ST_FRAME_ERR = 7;
  localparam logic [15:0] UART_MIN_DIV = 16'd4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/obi_uart.sv
// obi_uart: 8N1 UART as an OBI responder with TX/RX FIFOs, programmable divisor,
// sticky error flags and a registered level interrupt.
module obi_uart import soc_pkg::*; #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  localparam logic [15:0] RST_DIV = 16'(CLK_FREQ / BAUDRATE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [15:0] div_q, div_d, div_wr;
  logic rvalid_q, irq_q, rx_ovf_q, tx_ovf_q, ferr_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] reg_a;
  logic wr, rd, w1c;
  logic [7:0] status;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_q;
  logic [7:0] tx_dout, tx_sh_q;
  logic [CW-1:0] tx_cnt, rx_cnt;
  e_uart_st tx_st_q, rx_st_q;
  logic [15:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [2:0] tx_bit_q, rx_bit_q, rx_sync_q;
  logic rx_push, rx_pop, rx_full, rx_empty, rx_line, rx_fall, rx_stop, ferr_set, rx_ovf_set;
  logic [7:0] rx_dout, rx_sh_q;
  logic unused_ok;
  assign unused_ok = ^{obi_addr_i[31:4], obi_addr_i[1:0], obi_wdata_i[31:16], obi_be_i[3:2], tx_cnt, rx_cnt};
  assign obi_gnt_o    = obi_req_i;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign uart_tx_o    = tx_q;
  assign irq_o        = irq_q;
  assign wr    = obi_req_i & obi_we_i;
  assign rd    = obi_req_i & ~obi_we_i;
  assign reg_a = obi_addr_i[3:2];
  assign w1c   = wr & (reg_a == STATUS) & obi_be_i[0];
  assign tx_push = wr & (reg_a == DATA) & obi_be_i[0];
  assign rx_pop  = rd & (reg_a == DATA) & ~rx_empty;
  assign tx_busy = tx_st_q != S_IDLE;
  assign status  = {ferr_q, tx_ovf_q, rx_ovf_q, rx_full, rx_empty, tx_busy, tx_empty, tx_full};
  assign rdata_d = !rd ? '0 :
                   (reg_a == DATA)   ? (rx_empty ? '0 : {23'b0, 1'b1, rx_dout}) :
                   (reg_a == STATUS) ? {24'b0, status} :
                   (reg_a == DIV)    ? {16'b0, div_q} : '0;
  assign div_wr = {obi_be_i[1] ? obi_wdata_i[15:8] : div_q[15:8], obi_be_i[0] ? obi_wdata_i[7:0] : div_q[7:0]};
  assign div_d  = (wr & (reg_a == DIV)) ? (div_wr < UART_MIN_DIV ? UART_MIN_DIV : div_wr) : div_q;
  assign tx_pop = ~tx_empty & (tx_st_q == S_IDLE | (tx_st_q == S_STOP & tx_cnt_q == '0));
  assign rx_line    = rx_sync_q[1];
  assign rx_fall    = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_stop    = rx_st_q == S_STOP & rx_cnt_q == '0;
  assign rx_push    = rx_stop & rx_line;
  assign ferr_set   = rx_stop & ~rx_line;
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i, .rst_ni, .push_i(tx_push), .data_i(obi_wdata_i[7:0]), .pop_i(tx_pop),
    .data_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i, .rst_ni, .push_i(rx_push), .data_i(rx_sh_q), .pop_i(rx_pop),
    .data_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );
  // Sticky flags: a set in the same cycle as its W1C wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      div_q    <= RST_DIV;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i;
      rdata_q  <= rdata_d;
      div_q    <= div_d;
      tx_ovf_q <= (tx_push & tx_full & ~tx_pop) | (tx_ovf_q & ~(w1c & obi_wdata_i[ST_TX_OVF]));
      rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~(w1c & obi_wdata_i[ST_RX_OVF]));
      ferr_q   <= ferr_set | (ferr_q & ~(w1c & obi_wdata_i[ST_FRAME_ERR]));
      irq_q    <= ~rx_empty | rx_ovf_q | tx_ovf_q | ferr_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= RST_DIV;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else if (tx_pop) begin
      tx_st_q  <= S_START;
      tx_div_q <= div_q;
      tx_cnt_q <= div_q - 16'd1;
      tx_sh_q  <= tx_dout;
      tx_q     <= 1'b0;
    end else if (tx_st_q != S_IDLE) begin
      if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 16'd1;
      else begin
        tx_cnt_q <= tx_div_q - 16'd1;
        case (tx_st_q)
          S_START: begin
            tx_st_q  <= S_DATA;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
          S_DATA: begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= (tx_bit_q == 3'd7) ? 1'b1 : tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            if (tx_bit_q == 3'd7) tx_st_q <= S_STOP;
          end
          default: tx_st_q <= S_IDLE;
        endcase
      end
    end
  end
  // RX samples mid-bit: half a bit after the start edge, then every DIV cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 3'b111;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_div_q  <= RST_DIV;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[1:0], uart_rx_i};
      if (rx_st_q == S_IDLE) begin
        if (rx_fall) begin
          rx_st_q  <= S_START;
          rx_div_q <= div_q;
          rx_cnt_q <= (div_q >> 1) - 16'd1;
        end
      end else if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 16'd1;
      else begin
        rx_cnt_q <= rx_div_q - 16'd1;
        case (rx_st_q)
          S_START: begin
            rx_st_q  <= rx_line ? S_IDLE : S_DATA;
            rx_bit_q <= '0;
          end
          S_DATA: begin
            rx_sh_q  <= {rx_line, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
          end
          default: rx_st_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obi_uart.sv
// tb_obi_uart: directed checks of the OBI UART register map, TX/RX framing, flags and reset.
module tb_obi_uart;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] be = '0;
  logic gnt, rvalid, tx, irq;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  obi_uart dut (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
    .obi_rdata_o(rdata), .uart_tx_o(tx), .uart_rx_i(rx), .irq_o(irq)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = 4'hf; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    r = rdata;
    check("rvalid", {31'b0, rvalid}, 1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
    check("wr rdata", r, 0);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 0, r);
    check(tag, r, exp);
  endtask
  task automatic tx_byte(input int div, input logic [7:0] exp);
    logic [7:0] b;
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    repeat (div / 2) @(negedge clk);
    check("tx start bit", {31'b0, tx}, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = tx;
    end
    repeat (div) @(negedge clk);
    check("tx stop bit", {31'b0, tx}, 1);
    check("tx byte", {24'b0, b}, {24'b0, exp});
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop_b, input int div);
    logic [9:0] f;
    f = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (div) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] pat;
    repeat (3) @(negedge clk);
    check("reset tx", {31'b0, tx}, 1);
    check("reset irq", {31'b0, irq}, 0);
    check("reset rvalid", {31'b0, rvalid}, 0);
    check("reset rdata", rdata, 0);
    rst_n = 1'b1;
    // Exact one-cycle response timing on a DIV read.
    @(negedge clk);
    req = 1'b1; addr = 32'h8; be = 4'hf;
    check("gnt", {31'b0, gnt}, 1);
    check("rvalid in req cycle", {31'b0, rvalid}, 0);
    @(negedge clk);
    req = 1'b0;
    check("rvalid after req", {31'b0, rvalid}, 1);
    check("reset div", rdata, 32'hD9);
    @(negedge clk);
    check("rvalid drops", {31'b0, rvalid}, 0);
    check("rdata idle", rdata, 0);
    check("idle tx", {31'b0, tx}, 1);
    check("idle irq", {31'b0, irq}, 0);
    wr(32'h8, 32'h2);
    rd("div clamp", 32'h8, 32'h4);
    rd("reg c", 32'hC, 0);
    // TX 0x55 at DIV=4.
    wr(32'h8, 32'h4);
    wr(32'h0, 32'h55);
    check("tx before pop", {31'b0, tx}, 1);
    @(negedge clk);
    check("tx low after pop", {31'b0, tx}, 0);
    @(negedge clk);
    pat = 10'b1010101010;
    for (int i = 0; i < 10; i++) begin
      check("tx 0x55 bit", {31'b0, tx}, {31'b0, pat[i]});
      repeat (4) @(negedge clk);
    end
    rd("status after tx", 32'h4, 32'h0A);
    // Burst of 10 writes at DIV=217: the tenth overflows.
    wr(32'h8, 32'hD9);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hf;
    for (int i = 0; i < 10; i++) begin
      wdata = i;
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0;
    fork
      for (int i = 0; i < 9; i++) tx_byte(217, 8'(i));
      begin
        rd("status tx_ovf", 32'h4, 32'h4D);
        check("irq tx_ovf", {31'b0, irq}, 1);
        wr(32'h4, 32'h40);
        rd("status ovf clr", 32'h4, 32'h0D);
        check("irq cleared", {31'b0, irq}, 0);
      end
    join
    repeat (200) @(negedge clk);
    rd("status tx drained", 32'h4, 32'h0A);
    // RX 0xA5 at DIV=16.
    wr(32'h8, 32'h10);
    send_rx(8'hA5, 1'b1, 16);
    rd("status rx data", 32'h4, 32'h02);
    check("irq rx data", {31'b0, irq}, 1);
    rd("rx data", 32'h0, 32'h1A5);
    rd("rx empty read", 32'h0, 32'h0);
    check("irq rx drained", {31'b0, irq}, 0);
    send_rx(8'h3C, 1'b0, 16);
    rd("status frame err", 32'h4, 32'h8A);
    check("irq frame err", {31'b0, irq}, 1);
    wr(32'h4, 32'h80);
    rd("status ferr clr", 32'h4, 32'h0A);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rd("status glitch", 32'h4, 32'h0A);
    check("irq glitch", {31'b0, irq}, 0);
    for (int i = 0; i < 9; i++) send_rx(8'h30 + 8'(i), 1'b1, 16);
    rd("status rx ovf", 32'h4, 32'h32);
    check("irq rx ovf", {31'b0, irq}, 1);
    for (int i = 0; i < 8; i++) rd("rx fifo byte", 32'h0, 32'h130 + i);
    rd("rx ninth empty", 32'h0, 32'h0);
    wr(32'h4, 32'h20);
    rd("status rx ovf clr", 32'h4, 32'h0A);
    // Reset in the middle of a TX frame.
    wr(32'h0, 32'h00);
    repeat (40) @(negedge clk);
    check("tx mid frame", {31'b0, tx}, 0);
    #2 rst_n = 1'b0;
    #1 check("tx on reset", {31'b0, tx}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rd("status after reset", 32'h4, 32'h0A);
    rd("div after reset", 32'h8, 32'hD9);
    check("tx after reset", {31'b0, tx}, 1);
    check("irq after reset", {31'b0, irq}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
